// File: rtl/core_dmem_if.sv
`default_nettype none
// ============================================================================
// core_dmem_if : load/store bridge between the EXMEM stage and a req/gnt,
//                rvalid data bus, with per-phase timeout abort.
// Optional macro: DMEM_MISALIGN_TRAP_EN (trap misaligned LH/LHU/SH/LW/SW).
// Revision: 1.0
// ============================================================================
module core_dmem_if #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmem_start,
    input  logic              dmem_isload,
    input  logic              dmem_isstore,
    input  logic [2:0]        dmem_funct3,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [31:0]       dmem_wdata,
    output logic              hcu_dmem_busy,
    output logic              hcu_dmem_done,
    output logic [31:0]       dmem_rdata,
    output logic              dmem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;

    logic        w_accept;
    logic        w_misaligned;
    logic [3:0]  w_req_strb;
    logic [31:0] w_req_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_accept = (r_state == S_IDLE) & dmem_start & (dmem_isload | dmem_isstore);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misaligned = ((dmem_funct3[1:0] == 2'b01) & dmem_addr[0]) |
                          ((dmem_funct3[1:0] == 2'b10) & (dmem_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Busy rises in the start cycle so the pipeline stalls without a bubble.
    assign hcu_dmem_busy = ~rst & ((r_state == S_REQ) | (r_state == S_RSP) |
                                   (w_accept & ~w_misaligned));

    // Halfword lane follows ADDR[1]; ADDR[0] is dropped for halfwords.
    always_comb begin
        w_req_strb  = 4'b1111;
        w_req_wdata = dmem_wdata;
        case (dmem_funct3[1:0])
            2'b00: begin
                w_req_strb  = 4'b0001 << dmem_addr[1:0];
                w_req_wdata = {4{dmem_wdata[7:0]}};
            end
            2'b01: begin
                w_req_strb  = dmem_addr[1] ? 4'b1100 : 4'b0011;
                w_req_wdata = {2{dmem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = bus_rdata[7:0];
        case (r_lane)
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            2'd3:    w_byte = bus_rdata[31:24];
            default: w_byte = bus_rdata[7:0];
        endcase
        w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
            2'b01:   w_load_data = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
            default: w_load_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_funct3      <= 3'd0;
            r_lane        <= 2'd0;
            hcu_dmem_done <= 1'b0;
            dmem_err      <= 1'b0;
            dmem_rdata    <= 32'd0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= 32'd0;
            bus_wstrb     <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3   <= dmem_funct3;
                        r_lane     <= dmem_addr[1:0];
                        r_cnt      <= 8'd0;
                        dmem_rdata <= 32'd0;
                        if (w_misaligned) begin
                            r_state       <= S_DONE;
                            hcu_dmem_done <= 1'b1;
                            dmem_err      <= 1'b1;
                        end else begin
                            r_state   <= S_REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= ~dmem_isload;
                            bus_addr  <= {dmem_addr[ADDR_W-1:2], 2'b00};
                            bus_wstrb <= dmem_isload ? 4'd0 : w_req_strb;
                            bus_wdata <= dmem_isload ? 32'd0 : w_req_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        r_cnt   <= 8'd0;
                        r_state <= S_RSP;
                    end else if (r_cnt == C_TMO_LAST) begin
                        bus_req       <= 1'b0;
                        r_state       <= S_DONE;
                        hcu_dmem_done <= 1'b1;
                        dmem_err      <= 1'b1;
                        dmem_rdata    <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RSP: begin
                    if (bus_rvalid) begin
                        r_state       <= S_DONE;
                        hcu_dmem_done <= 1'b1;
                        if (!bus_we) begin
                            dmem_rdata <= w_load_data;
                        end
                    end else if (r_cnt == C_TMO_LAST) begin
                        r_state       <= S_DONE;
                        hcu_dmem_done <= 1'b1;
                        dmem_err      <= 1'b1;
                        dmem_rdata    <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    hcu_dmem_done <= 1'b0;
                    dmem_err      <= 1'b0;
                    r_cnt         <= 8'd0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_dmem_if.sv
`default_nettype none
// ============================================================================
// tb_core_dmem_if : randomized scoreboard bench for core_dmem_if.
// Revision: 1.0
// ============================================================================
module tb_core_dmem_if;

    localparam int T  = 4;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          dmem_start, dmem_isload, dmem_isstore;
    logic [2:0]    dmem_funct3;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          hcu_dmem_busy, hcu_dmem_done, dmem_err;
    logic [31:0]   dmem_rdata;
    logic          bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata, bus_rdata;
    logic [3:0]    bus_wstrb;

    core_dmem_if #(.TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .dmem_start(dmem_start), .dmem_isload(dmem_isload), .dmem_isstore(dmem_isstore),
        .dmem_funct3(dmem_funct3), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .hcu_dmem_busy(hcu_dmem_busy), .hcu_dmem_done(hcu_dmem_done),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        has_req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        err;
        int          done_cyc;
    } txn_t;

    txn_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] brd);
        logic [31:0] v;
        if (f3[1:0] == 2'd0) begin
            v = (brd >> (8 * (addr % 4))) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'd1) begin
            v = (brd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = brd;
        end
        return v;
    endfunction

    function automatic txn_t build(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] brd,
                                   input int dg, input int dr, input int c0);
        txn_t t;
        bit   mis;
        mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (f3[1:0] == 2'd1 && (addr % 2) != 0) || (f3[1:0] == 2'd2 && (addr % 4) != 0);
`endif
        t.has_req = !mis;
        t.we      = !ld;
        t.addr    = addr & 32'hFFFF_FFFC;
        if (ld) begin
            t.strb  = 4'h0;
            t.wdata = 32'h0;
        end else if (f3[1:0] == 2'd0) begin
            t.strb  = 4'(1 << (addr % 4));
            t.wdata = (wd & 32'hFF) * 32'h0101_0101;
        end else if (f3[1:0] == 2'd1) begin
            t.strb  = ((addr / 2) % 2 != 0) ? 4'hC : 4'h3;
            t.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
        end else begin
            t.strb  = 4'hF;
            t.wdata = wd;
        end
        t.chk_rdata = 1'b1;
        t.rdata     = 32'h0;
        if (mis) begin
            t.err = 1'b1; t.chk_rdata = 1'b0; t.done_cyc = c0 + 1;
        end else if (dg >= T) begin
            t.err = 1'b1; t.done_cyc = c0 + T + 1;
        end else if (dr >= T) begin
            t.err = 1'b1; t.done_cyc = c0 + 2 + dg + T;
        end else begin
            t.err = 1'b0; t.chk_rdata = ld; t.done_cyc = c0 + 3 + dg + dr;
            if (ld) t.rdata = load_model(f3, addr, brd);
        end
        return t;
    endfunction

    // Called and returns on a falling edge with the DUT idle.
    task automatic run_txn(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] brd, input int dg, input int dr);
        txn_t t;
        t = build(ld, f3, addr, wd, brd, dg, dr, cyc);
        q.push_back(t);
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        dmem_start = 1'b1; dmem_isload = ld; dmem_isstore = !ld;
        dmem_funct3 = f3; dmem_addr = addr; dmem_wdata = wd;
        #1 check("busy_on_start", {31'd0, hcu_dmem_busy}, {31'd0, t.has_req});
        @(negedge clk);
        dmem_start = 1'b0;
        dmem_addr = $urandom; dmem_wdata = $urandom;
        if (t.has_req) begin
            for (int k = 0; k < T; k++) begin
                bus_gnt    = (k == dg);
                bus_rvalid = (k == dg) ? 1'($urandom) : 1'b0;
                @(negedge clk);
                bus_gnt = 1'b0; bus_rvalid = 1'b0;
                if (k == dg) break;
            end
            if (dg < T) begin
                for (int k = 0; k < T; k++) begin
                    bus_rvalid   = (k == dr);
                    bus_rdata    = (k == dr) ? brd : $urandom;
                    dmem_start   = ($urandom_range(0, 3) == 0);
                    dmem_isload  = 1'($urandom);
                    dmem_isstore = 1'($urandom);
                    dmem_funct3  = 3'($urandom);
                    @(negedge clk);
                    bus_rvalid = 1'b0; dmem_start = 1'b0;
                    if (k == dr) break;
                end
            end
        end
        @(negedge clk);
        repeat ($urandom_range(0, 2)) begin
            bus_gnt = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
            @(negedge clk);
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
        check({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
        check({tag, "_bus_addr"}, bus_addr, 32'd0);
        check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        check({tag, "_bus_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
        check({tag, "_busy"}, {31'd0, hcu_dmem_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, hcu_dmem_done}, 32'd0);
        check({tag, "_err"}, {31'd0, dmem_err}, 32'd0);
        check({tag, "_rdata"}, dmem_rdata, 32'd0);
    endtask

    // Monitor: bus request fields at handshake, completion at the done pulse.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (bus_req && q.size() == 0) begin
                check("req_without_txn", {31'd0, bus_req}, 32'd0);
            end else if (bus_req && !q[0].has_req) begin
                check("req_on_trap", {31'd0, bus_req}, 32'd0);
            end else if (bus_req && bus_gnt) begin
                check("bus_we", {31'd0, bus_we}, {31'd0, q[0].we});
                check("bus_addr", bus_addr, q[0].addr);
                check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, q[0].strb});
                if (q[0].we) check("bus_wdata", bus_wdata, q[0].wdata);
            end
            if (hcu_dmem_done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", {31'd0, hcu_dmem_done}, 32'd0);
                end else begin
                    txn_t t;
                    t = q.pop_front();
                    check("done_cycle", cyc, t.done_cyc);
                    check("err", {31'd0, dmem_err}, {31'd0, t.err});
                    check("busy_at_done", {31'd0, hcu_dmem_busy}, 32'd0);
                    check("req_at_done", {31'd0, bus_req}, 32'd0);
                    if (t.chk_rdata) check("rdata", dmem_rdata, t.rdata);
                end
            end
        end
    end

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        txn_t       t;
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
        st_f3[0] = 3'b000; st_f3[1] = 3'b001; st_f3[2] = 3'b010;

        rst = 1'b1; dmem_start = 1'b0; dmem_isload = 1'b0; dmem_isstore = 1'b0;
        dmem_funct3 = 3'd0; dmem_addr = '0; dmem_wdata = 32'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_txn(1'b1, 3'b000, 32'h0000_0203, 32'h0, 32'h8000_0000, 0, 0);
        run_txn(1'b1, 3'b100, 32'h0000_0203, 32'h0, 32'h8000_0000, 0, 0);
        run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 1, 0);
        run_txn(1'b1, 3'b010, 32'h0000_0300, 32'h0, 32'h1234_5678, 10, 0);
        run_txn(1'b1, 3'b010, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 0, 0);
        run_txn(1'b1, 3'b001, 32'h0000_0203, 32'h0, 32'h9ABC_5678, 0, 1);
        run_txn(1'b1, 3'b101, 32'h0000_0206, 32'h0, 32'h9ABC_5678, 2, 2);
        run_txn(1'b0, 3'b010, 32'h0000_0042, 32'h1122_3344, 32'h0, 0, 0);
        run_txn(1'b1, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 1, 9);

        // Reset during the response phase: the late rvalid must not complete anything.
        t = build(1'b1, 3'b010, 32'h0000_0080, 32'h0, 32'h0, 0, 0, cyc);
        q.push_back(t);
        dmem_start = 1'b1; dmem_isload = 1'b1; dmem_isstore = 1'b0;
        dmem_funct3 = 3'b010; dmem_addr = 32'h0000_0080;
        @(negedge clk);
        dmem_start = 1'b0; bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check_all_zero("midrst");
        q.delete();
        @(negedge clk);
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_all_zero("postrst");
        @(negedge clk);

        for (int i = 0; i < 50; i++) begin
            logic       ld;
            logic [2:0] f3;
            ld = 1'($urandom);
            f3 = ld ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
            run_txn(ld, f3, $urandom, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 5));
        end

        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
